// File: rtl/mips_alu.sv
// 32-bit ALU for the multicycle MIPS datapath.
// Produces a combinational result, zero and overflow flags, and a registered copy (ALUOut).
module mips_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic [2:0]  alucontrol,
  output logic [31:0] aluresult,
  output logic        zero,
  output logic        overflow,
  output logic [31:0] aluout
);

  logic [31:0] bb_s;
  logic [31:0] sum_s;
  logic        ovf_s;
  logic [31:0] aluout_r;

  // Shared adder: B is inverted and the carry-in is set for SUB/SLT and the negated-B logic ops.
  always_comb begin
    bb_s  = 32'h0;
    sum_s = 32'h0;
    ovf_s = 1'b0;
    if (alucontrol[2] == 1'b1) begin
      bb_s = ~srcb;
    end else begin
      bb_s = srcb;
    end
    sum_s = srca + bb_s + {31'b0, alucontrol[2]};
    ovf_s = (srca[31] == bb_s[31]) && (sum_s[31] != srca[31]);
  end

  // Result select; undefined codes fall to zero so nothing X-dependent is held.
  always_comb begin
    aluresult = 32'h0;
    overflow  = 1'b0;
    case (alucontrol)
      3'b000: aluresult = srca & srcb;
      3'b001: aluresult = srca | srcb;
      3'b010: begin
        aluresult = sum_s;
        overflow  = ovf_s;
      end
      3'b011: aluresult = 32'h0;
      3'b100: aluresult = srca & bb_s;
      3'b101: aluresult = srca | bb_s;
      3'b110: begin
        aluresult = sum_s;
        overflow  = ovf_s;
      end
      3'b111: aluresult = {31'b0, sum_s[31] ^ ovf_s};
      default: begin
        aluresult = 32'h0;
        overflow  = 1'b0;
      end
    endcase
  end

  // Zero flag follows the final result for every code.
  always_comb begin
    zero = (aluresult == 32'h0);
  end

  // ALUOut register, loaded every edge; reset dominates a coincident edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aluout_r <= 32'h0;
    end else begin
      aluout_r <= aluresult;
    end
  end

  assign aluout = aluout_r;

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: directed cases from the ALU's rules plus
// random operands checked against a signed-arithmetic reference model.
module tb_mips_alu;

  logic        clk;
  logic        reset;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [2:0]  alucontrol;
  logic [31:0] aluresult;
  logic        zero;
  logic        overflow;
  logic [31:0] aluout;

  int n_cmp = 0;
  int n_mis = 0;

  mips_alu dut (
    .clk        (clk),
    .reset      (reset),
    .srca       (srca),
    .srcb       (srcb),
    .alucontrol (alucontrol),
    .aluresult  (aluresult),
    .zero       (zero),
    .overflow   (overflow),
    .aluout     (aluout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain two's-complement arithmetic on wide signed values.
  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] ctl);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (ctl)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b011:  return 32'h0;
      3'b100:  return a & ~b;
      3'b101:  return a | ~b;
      3'b110:  return a - b;
      3'b111:  return (sa < sb) ? 32'h1 : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] ctl);
    longint sa;
    longint sb;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (ctl == 3'b010) r = sa + sb;
    else if (ctl == 3'b110) r = sa - sb;
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply operands between edges, check comb outputs, then the registered copy after the edge.
  task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] ctl);
    logic [31:0] er;
    @(negedge clk);
    srca = a;
    srcb = b;
    alucontrol = ctl;
    er = ref_result(a, b, ctl);
    #1;
    chk({tag, ".res"}, aluresult, er);
    chk({tag, ".zero"}, {31'b0, zero}, {31'b0, (er == 32'h0)});
    chk({tag, ".ovf"}, {31'b0, overflow}, {31'b0, ref_ovf(a, b, ctl)});
    @(posedge clk);
    #1;
    chk({tag, ".aluout"}, aluout, er);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  c;
    reset = 1'b1;
    srca = 32'h0;
    srcb = 32'h0;
    alucontrol = 3'b000;
    #1;
    chk("reset.aluout", aluout, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases, constants fixed by the ALU's definition.
    apply("add4", 32'h00000004, 32'h00000004, 3'b010);
    chk("add4.const", aluout, 32'h00000008);
    apply("beq_eq", 32'h12345678, 32'h12345678, 3'b110);
    chk("beq_eq.zero", {31'b0, zero}, 32'h1);
    apply("beq_ne", 32'h12345678, 32'h12345679, 3'b110);
    chk("beq_ne.const", aluresult, 32'hFFFFFFFF);
    apply("and", 32'hF0F0F0F0, 32'h0FF00FF0, 3'b000);
    chk("and.const", aluresult, 32'h00F000F0);
    apply("or", 32'hF0F0F0F0, 32'h0FF00FF0, 3'b001);
    chk("or.const", aluresult, 32'hFFF0FFF0);
    apply("andn", 32'hF0F0F0F0, 32'h0FF00FF0, 3'b100);
    chk("andn.const", aluresult, 32'hF000F000);
    apply("orn", 32'hF0F0F0F0, 32'h0FF00FF0, 3'b101);
    chk("orn.const", aluresult, 32'hF0FFF0FF);
    apply("unused", 32'hF0F0F0F0, 32'h0FF00FF0, 3'b011);
    chk("unused.const", aluresult, 32'h0);
    apply("slt_m1_1", 32'hFFFFFFFF, 32'h00000001, 3'b111);
    chk("slt_m1_1.const", aluresult, 32'h1);
    apply("slt_1_m1", 32'h00000001, 32'hFFFFFFFF, 3'b111);
    chk("slt_1_m1.const", aluresult, 32'h0);
    apply("slt_5_5", 32'h00000005, 32'h00000005, 3'b111);
    chk("slt_5_5.zero", {31'b0, zero}, 32'h1);
    apply("slt_ovf", 32'h80000000, 32'h00000001, 3'b111);
    chk("slt_ovf.const", aluresult, 32'h1);
    apply("add_ovf", 32'h7FFFFFFF, 32'h00000001, 3'b010);
    chk("add_ovf.flag", {31'b0, overflow}, 32'h1);
    chk("add_ovf.const", aluresult, 32'h80000000);
    apply("add_wrap", 32'hFFFFFFFF, 32'h00000001, 3'b010);
    chk("add_wrap.zero", {31'b0, zero}, 32'h1);
    chk("add_wrap.flag", {31'b0, overflow}, 32'h0);
    apply("sub_ovf", 32'h80000000, 32'h00000001, 3'b110);
    chk("sub_ovf.const", aluresult, 32'h7FFFFFFF);
    chk("sub_ovf.flag", {31'b0, overflow}, 32'h1);
    apply("sub_minint", 32'h00000000, 32'h80000000, 3'b110);

    // Reset mid-cycle: aluout clears immediately, comb path keeps tracking.
    apply("preload", 32'h00000004, 32'h00000004, 3'b010);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst.async", aluout, 32'h0);
    srca = 32'h00000010;
    srcb = 32'h00000003;
    alucontrol = 3'b110;
    #1;
    chk("rst.comb", aluresult, 32'h0000000D);
    @(posedge clk);
    #1;
    chk("rst.hold", aluout, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst.release", aluout, 32'h0);
    @(posedge clk);
    #1;
    chk("rst.reload", aluout, 32'h0000000D);

    // Random operands, with some corner values mixed in.
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      b = $urandom;
      c = 3'($urandom_range(7, 0));
      case ($urandom_range(5, 0))
        0: b = a;
        1: a = 32'h80000000;
        2: b = 32'h7FFFFFFF;
        default: ;
      endcase
      apply("rand", a, b, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
